// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage pipeline control logic.
//   state_e       : sequencing controller state encoding (INIT/RUN/MEM_WAIT)
//   RegIdxW       : register-file index width
//   DefaultStatW  : default width of the statistics counters
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      StInit    = 2'd0,
      StRun     = 2'd1,
      StMemWait = 2'd2
   } state_e;

   localparam int unsigned RegIdxW      = 5;
   localparam int unsigned DefaultStatW = 16;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_reset : synchronous active-high reset (zeroes the count)
//   i_clr   : synchronous clear, wins over i_inc
//   i_inc   : increment request; ignored once the count is all-ones
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller: post-reset clear sequence, load-use bubble
// insertion, EX-redirect flush and whole-pipeline freeze on data-memory busy.
// Keeps saturating stall/flush statistics.
//   clock, reset          : clock, synchronous active-high reset
//   clear_stats           : zero both statistics counters
//   id_rs, id_rt          : decode-stage source registers
//   id_uses_rt            : decode instruction reads rt
//   ex_memread, ex_rt     : EX-stage load flag and destination
//   ex_redirect           : taken branch/jump resolved in EX
//   mem_busy              : data memory not ready
//   *_write / *_reset     : pipeline register write enables / clears
//   state                 : 0=INIT, 1=RUN, 2=MEM_WAIT
//   stall_count           : cycles (outside INIT) with pc_write=0
//   flush_count           : cycles in which a redirect flush was applied
// All control outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned INIT_CYCLES = 2,
   parameter int unsigned STAT_W      = DefaultStatW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear_stats,
   input  logic [RegIdxW-1:0] id_rs,
   input  logic [RegIdxW-1:0] id_rt,
   input  logic               id_uses_rt,
   input  logic               ex_memread,
   input  logic [RegIdxW-1:0] ex_rt,
   input  logic               ex_redirect,
   input  logic               mem_busy,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               id_ex_write,
   output logic               ex_mem_write,
   output logic               mem_wb_write,
   output logic               if_id_reset,
   output logic               id_ex_reset,
   output logic               ex_mem_reset,
   output logic               mem_wb_reset,
   output logic [1:0]         state,
   output logic [STAT_W-1:0]  stall_count,
   output logic [STAT_W-1:0]  flush_count
);

   // Wide enough to hold INIT_CYCLES-1 even when INIT_CYCLES is 1.
   localparam int unsigned     CntW    = $clog2(INIT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(INIT_CYCLES - 1);

   state_e          r_state;
   logic [CntW-1:0] r_init_cnt;

   logic w_active;
   logic w_load_use;
   logic w_flush;
   logic w_stall_inc;
   logic w_flush_inc;

   // RUN and MEM_WAIT share the same control rules; encoding 3 falls to INIT.
   assign w_active = !reset && ((r_state == StRun) || (r_state == StMemWait));

   assign w_load_use = ex_memread && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   assign w_flush = w_active && !mem_busy && ex_redirect;

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_reset  = 1'b0;
      id_ex_reset  = 1'b0;
      ex_mem_reset = 1'b0;
      mem_wb_reset = 1'b0;
      if (!w_active) begin
         if_id_reset  = 1'b1;
         id_ex_reset  = 1'b1;
         ex_mem_reset = 1'b1;
         mem_wb_reset = 1'b1;
      end else if (mem_busy) begin
         // Freeze: every register holds, including EX, so a pending
         // redirect stays visible and is applied once memory is ready.
      end else if (ex_redirect) begin
         pc_write     = 1'b1;
         if_id_reset  = 1'b1;
         id_ex_reset  = 1'b1;
         ex_mem_write = 1'b1;
         mem_wb_write = 1'b1;
      end else if (w_load_use) begin
         // Hold PC and IF_ID, drop a bubble into ID_EX.
         id_ex_reset  = 1'b1;
         ex_mem_write = 1'b1;
         mem_wb_write = 1'b1;
      end else begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         id_ex_write  = 1'b1;
         ex_mem_write = 1'b1;
         mem_wb_write = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= StInit;
         r_init_cnt <= '0;
      end else begin
         unique case (r_state)
            StRun, StMemWait: begin
               r_state <= mem_busy ? StMemWait : StRun;
            end
            default: begin
               if (r_init_cnt == CntLast) begin
                  r_state    <= StRun;
                  r_init_cnt <= '0;
               end else begin
                  r_init_cnt <= r_init_cnt + CntW'(1);
               end
            end
         endcase
      end
   end

   assign state = reset ? StInit : r_state;

   assign w_stall_inc = w_active && !pc_write;
   assign w_flush_inc = w_flush;

   sat_counter #(
      .WIDTH (STAT_W)
   ) u_stall_cnt (
      .i_clk   (clock),
      .i_reset (reset),
      .i_clr   (clear_stats),
      .i_inc   (w_stall_inc),
      .o_count (stall_count)
   );

   sat_counter #(
      .WIDTH (STAT_W)
   ) u_flush_cnt (
      .i_clk   (clock),
      .i_reset (reset),
      .i_clr   (clear_stats),
      .i_inc   (w_flush_inc),
      .o_count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (INIT_CYCLES=2, STAT_W=4).
// Control outputs are packed as
//   {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
//    if_id_reset, id_ex_reset, ex_mem_reset, mem_wb_reset}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam logic [8:0] CtlInit  = 9'b00000_1111;
   localparam logic [8:0] CtlNorm  = 9'b11111_0000;
   localparam logic [8:0] CtlFrz   = 9'b00000_0000;
   localparam logic [8:0] CtlFlush = 9'b10011_1100;
   // id_ex_write is not constrained during a load-use bubble.
   localparam logic [8:0] LuMask   = 9'b11011_1111;
   localparam logic [8:0] CtlLu    = 9'b00011_0100;

   logic       clock = 1'b0;
   logic       reset;
   logic       clear_stats;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_memread, ex_redirect, mem_busy;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic       if_id_reset, id_ex_reset, ex_mem_reset, mem_wb_reset;
   logic [1:0] state;
   logic [3:0] stall_count, flush_count;
   logic [8:0] ctrl;

   int n_cmp = 0;
   int n_bad = 0;

   assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_reset, id_ex_reset, ex_mem_reset, mem_wb_reset};

   always #5 clock = ~clock;

   hazard_ctrl #(
      .INIT_CYCLES (2),
      .STAT_W      (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .clear_stats  (clear_stats),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_memread   (ex_memread),
      .ex_rt        (ex_rt),
      .ex_redirect  (ex_redirect),
      .mem_busy     (mem_busy),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_write  (id_ex_write),
      .ex_mem_write (ex_mem_write),
      .mem_wb_write (mem_wb_write),
      .if_id_reset  (if_id_reset),
      .id_ex_reset  (id_ex_reset),
      .ex_mem_reset (ex_mem_reset),
      .mem_wb_reset (mem_wb_reset),
      .state        (state),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   // Advance past the next rising edge; inputs set afterwards settle by #2.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      clear_stats = 1'b0;
      id_rs       = 5'd0;
      id_rt       = 5'd0;
      id_uses_rt  = 1'b0;
      ex_memread  = 1'b0;
      ex_rt       = 5'd0;
      ex_redirect = 1'b0;
      mem_busy    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      settle();
      n_cmp++;
      if (ctrl !== CtlInit) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b expected %b", ctrl, CtlInit);
      end
      n_cmp++;
      if (state !== 2'd0 || stall_count !== 4'd0 || flush_count !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_state: got st=%0d stall=%0d flush=%0d expected 0/0/0",
                  state, stall_count, flush_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         n_cmp++;
         if (ctrl !== CtlInit || state !== 2'd0) begin
            n_bad++;
            $display("FAIL init_cycle%0d: got ctrl=%b st=%0d expected %b st=0",
                     i, ctrl, state, CtlInit);
         end
         step();
      end
      settle();
      n_cmp++;
      if (ctrl !== CtlNorm || state !== 2'd1) begin
         n_bad++;
         $display("FAIL init_to_run: got ctrl=%b st=%0d expected %b st=1", ctrl, state, CtlNorm);
      end
      n_cmp++;
      if (stall_count !== 4'd0) begin
         n_bad++;
         $display("FAIL init_no_stall_count: got %0d expected 0", stall_count);
      end
   endtask

   task automatic test_load_use();
      ex_memread = 1'b1;
      ex_rt      = 5'd5;
      id_rs      = 5'd5;
      settle();
      n_cmp++;
      if ((ctrl & LuMask) !== CtlLu) begin
         n_bad++;
         $display("FAIL load_use_ctrl: got %b expected %b", ctrl & LuMask, CtlLu);
      end
      step();
      ex_memread = 1'b0;
      settle();
      n_cmp++;
      if (stall_count !== 4'd1) begin
         n_bad++;
         $display("FAIL load_use_count: got %0d expected 1", stall_count);
      end
      n_cmp++;
      if (ctrl !== CtlNorm) begin
         n_bad++;
         $display("FAIL after_bubble: got %b expected %b", ctrl, CtlNorm);
      end
      step();
   endtask

   task automatic test_no_hazard();
      ex_memread = 1'b1;
      ex_rt      = 5'd0;
      id_rs      = 5'd0;
      settle();
      n_cmp++;
      if (ctrl !== CtlNorm) begin
         n_bad++;
         $display("FAIL rt_zero: got %b expected %b", ctrl, CtlNorm);
      end
      ex_rt      = 5'd7;
      id_rt      = 5'd7;
      id_rs      = 5'd3;
      id_uses_rt = 1'b0;
      settle();
      n_cmp++;
      if (ctrl !== CtlNorm) begin
         n_bad++;
         $display("FAIL rt_unused: got %b expected %b", ctrl, CtlNorm);
      end
      id_uses_rt = 1'b1;
      settle();
      n_cmp++;
      if ((ctrl & LuMask) !== CtlLu) begin
         n_bad++;
         $display("FAIL rt_used: got %b expected %b", ctrl & LuMask, CtlLu);
      end
      step();
      idle_inputs();
      settle();
      n_cmp++;
      if (stall_count !== 4'd2) begin
         n_bad++;
         $display("FAIL rt_used_count: got %0d expected 2", stall_count);
      end
   endtask

   task automatic test_redirect_priority();
      ex_redirect = 1'b1;
      ex_memread  = 1'b1;
      ex_rt       = 5'd9;
      id_rs       = 5'd9;
      settle();
      n_cmp++;
      if (ctrl !== CtlFlush) begin
         n_bad++;
         $display("FAIL flush_ctrl: got %b expected %b", ctrl, CtlFlush);
      end
      step();
      idle_inputs();
      settle();
      n_cmp++;
      if (flush_count !== 4'd1 || stall_count !== 4'd2) begin
         n_bad++;
         $display("FAIL flush_counts: got flush=%0d stall=%0d expected 1/2",
                  flush_count, stall_count);
      end
   endtask

   task automatic test_mem_busy();
      mem_busy    = 1'b1;
      ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_cmp++;
         if (ctrl !== CtlFrz) begin
            n_bad++;
            $display("FAIL freeze%0d: got %b expected %b", i, ctrl, CtlFrz);
         end
         step();
         n_cmp++;
         if (state !== 2'd2) begin
            n_bad++;
            $display("FAIL freeze_state%0d: got %0d expected 2", i, state);
         end
      end
      mem_busy = 1'b0;
      settle();
      n_cmp++;
      if (stall_count !== 4'd5 || flush_count !== 4'd1) begin
         n_bad++;
         $display("FAIL freeze_counts: got stall=%0d flush=%0d expected 5/1",
                  stall_count, flush_count);
      end
      n_cmp++;
      if (ctrl !== CtlFlush || state !== 2'd2) begin
         n_bad++;
         $display("FAIL post_freeze_flush: got ctrl=%b st=%0d expected %b st=2",
                  ctrl, state, CtlFlush);
      end
      step();
      idle_inputs();
      settle();
      n_cmp++;
      if (state !== 2'd1 || flush_count !== 4'd2 || stall_count !== 4'd5) begin
         n_bad++;
         $display("FAIL back_to_run: got st=%0d flush=%0d stall=%0d expected 1/2/5",
                  state, flush_count, stall_count);
      end
   endtask

   task automatic test_clear_stats();
      clear_stats = 1'b1;
      ex_memread  = 1'b1;
      ex_rt       = 5'd4;
      id_rs       = 5'd4;
      step();
      idle_inputs();
      settle();
      n_cmp++;
      if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
         n_bad++;
         $display("FAIL clear_stats: got stall=%0d flush=%0d expected 0/0",
                  stall_count, flush_count);
      end
   endtask

   task automatic test_saturation();
      ex_memread = 1'b1;
      ex_rt      = 5'd12;
      id_rs      = 5'd12;
      for (int i = 0; i < 14; i++) step();
      settle();
      n_cmp++;
      if (stall_count !== 4'd14) begin
         n_bad++;
         $display("FAIL sat_pre: got %0d expected 14", stall_count);
      end
      for (int i = 0; i < 6; i++) step();
      settle();
      n_cmp++;
      if (stall_count !== 4'd15) begin
         n_bad++;
         $display("FAIL sat_hold: got %0d expected 15", stall_count);
      end
      clear_stats = 1'b1;
      step();
      idle_inputs();
      settle();
      n_cmp++;
      if (stall_count !== 4'd0) begin
         n_bad++;
         $display("FAIL sat_clear: got %0d expected 0", stall_count);
      end
   endtask

   task automatic test_reset_mid_wait();
      mem_busy = 1'b1;
      ex_rt    = 5'd1;
      step();
      settle();
      n_cmp++;
      if (state !== 2'd2) begin
         n_bad++;
         $display("FAIL enter_wait: got %0d expected 2", state);
      end
      reset = 1'b1;
      settle();
      n_cmp++;
      if (ctrl !== CtlInit || state !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_in_wait: got ctrl=%b st=%0d expected %b st=0",
                  ctrl, state, CtlInit);
      end
      step();
      reset    = 1'b0;
      mem_busy = 1'b0;
      // One INIT cycle, then reset again: INIT must restart from the top.
      settle();
      n_cmp++;
      if (ctrl !== CtlInit || state !== 2'd0 || stall_count !== 4'd0) begin
         n_bad++;
         $display("FAIL wait_reset_init: got ctrl=%b st=%0d stall=%0d expected %b/0/0",
                  ctrl, state, stall_count, CtlInit);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         n_cmp++;
         if (ctrl !== CtlInit || state !== 2'd0) begin
            n_bad++;
            $display("FAIL reinit_cycle%0d: got ctrl=%b st=%0d expected %b st=0",
                     i, ctrl, state, CtlInit);
         end
         step();
      end
      settle();
      n_cmp++;
      if (ctrl !== CtlNorm || state !== 2'd1) begin
         n_bad++;
         $display("FAIL reinit_run: got ctrl=%b st=%0d expected %b st=1", ctrl, state, CtlNorm);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_redirect_priority();
      test_mem_busy();
      test_clear_stats();
      test_saturation();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage processor. It drives the write-enable and clear inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It sequences a multi-cycle pipeline clear after reset, inserts load-use bubbles, flushes wrong-path instructions on EX-resolved redirects, and freezes the whole pipeline while data memory is busy. It also keeps saturating stall and flush statistics counters.

## Interface
Parameters:
- INIT_CYCLES, default 2: number of cycles (≥1) all pipeline registers are held cleared after reset.
- STAT_W, default 16: width of the statistics counters.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- clear_stats  in  1  synchronous clear of both statistics counters.
- id_rs, id_rt  in  5 each  source registers of the instruction in decode (from IF_ID).
- id_uses_rt  in  1  decode instruction reads rt as a source.
- ex_memread  in  1  MemRead of the instruction in EX (ID_EX output).
- ex_rt  in  5  rt/destination of the instruction in EX (ID_EX output).
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_busy  in  1  data memory not ready this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register write enables.
- if_id_reset, id_ex_reset, ex_mem_reset, mem_wb_reset  out  1 each  register clears.
- state  out  2  INIT=0, RUN=1, MEM_WAIT=2.
- stall_count, flush_count  out  STAT_W each  statistics.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: INIT, RUN, MEM_WAIT. State 3 is unreachable and decodes as INIT.
- INIT:
  - all four clears = 1; all write enables = 0.
  - init_cnt counts 0..INIT_CYCLES-1, then state moves to RUN.
  - inputs are ignored.
- RUN, and MEM_WAIT with mem_busy=0: control signals are resolved with this priority, highest first.
  - 1. mem_busy=1 (freeze): all writes = 0, all clears = 0, next state = MEM_WAIT.
  - 2. ex_redirect=1 (flush): pc_write=1, if_id_reset=1, id_ex_reset=1, ex_mem_write=1, mem_wb_write=1. if_id_write and id_ex_write are don't-care and are driven 0.
  - 3. load-use hazard: pc_write=0, if_id_write=0, id_ex_reset=1, ex_mem_write=1, mem_wb_write=1.
  - 4. normal: all writes = 1, all clears = 0.
- Load-use hazard is defined as: ex_memread && ex_rt≠0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- MEM_WAIT: stays in MEM_WAIT while mem_busy=1. At the first edge with mem_busy=0 the state returns to RUN. The cycle with mem_busy=0 applies RUN rules.
- A redirect that coincides with mem_busy is not latched. EX is frozen, so ex_redirect is still asserted after the freeze and is applied then.
- stall_count: +1 on every non-INIT cycle with pc_write=0.
- flush_count: +1 on every cycle in which the flush rule applies.
- Both counters saturate at all-ones.
- clear_stats=1 zeroes both counters and overrides any increment in that cycle.

## Timing
- All outputs are combinational (Mealy) from current state and inputs, with 0-cycle latency.
- State, init_cnt and counters update on posedge clock.
- While reset=1, outputs equal INIT outputs combinationally.
- At the edge where reset=1: state←INIT, init_cnt←0, stall_count←0, flush_count←0.
- Reset values: state=0; clears=1; writes=0; counters=0.
- After reset deasserts, clears stay 1 for exactly INIT_CYCLES cycles; the next cycle is RUN.
- Reset asserted mid-MEM_WAIT or mid-INIT restarts INIT from init_cnt=0.
- A load-use bubble lasts one cycle: after the bubble, ID_EX holds a bubble with ex_memread=0, so no re-detection occurs.

## Structure
- Shared package pipe_pkg holds:
  - state encoding typedef (INIT/RUN/MEM_WAIT).
  - register-index width constant (5).
  - default STAT_W.
- One natural sub-module, sat_counter (STAT_W wide: inc, clr, saturate), instantiated twice.
- The hazard comparator is inline combinational logic.

## Test plan
- Reset 1 cycle, INIT_CYCLES=2 → two cycles with all clears=1 and pc_write=0; third cycle: state=RUN, all writes=1, clears=0.
- RUN, ex_memread=1, ex_rt=5, id_rs=5 → pc_write=0, if_id_write=0, id_ex_reset=1, ex_mem_write=1; stall_count 0→1. Next cycle with ex_memread=0 → all writes=1.
- ex_memread=1, ex_rt=0, id_rs=0 → no stall. ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- ex_redirect=1 together with a load-use hazard → pc_write=1, if_id_reset=1, id_ex_reset=1; flush_count +1; stall_count unchanged.
- mem_busy=1 for 3 cycles with ex_redirect=1 → all writes 0 for 3 cycles, state=MEM_WAIT, stall_count +3, flush_count +0; 4th cycle flush applies and state returns to RUN.
- STAT_W=4 with 20 consecutive stall cycles → stall_count=15; clear_stats → 0. Reset asserted mid-MEM_WAIT → INIT, clears=1 for INIT_CYCLES cycles.
